// File: rtl/contador_updown_mod_pkg.sv
// Shared definitions for the push-button up/down counter: default parameter
// values, the priority-mux selector type and a ceil(log2) helper used to size
// the debounce stable counters.
package contador_updown_mod_pkg;

    localparam int DEF_WIDTH           = 4;
    localparam int DEF_MODULO          = 10;
    localparam int DEF_DEBOUNCE_CYCLES = 4;
    localparam int DEF_INIT            = 0;

    // Which action the counter takes this cycle, in priority order.
    typedef enum logic [2:0] {
        SEL_HOLD,
        SEL_LOAD,
        SEL_CANCEL,
        SEL_UP,
        SEL_DOWN
    } step_sel_e;

    // Smallest r such that 2**r >= value.
    function automatic int clog2(input int value);
        int result;
        result = 0;
        while ((1 << result) < value) begin
            result = result + 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/contador_updown_mod_boton_pulso.sv
// One raw push-button: two-flop synchroniser, counting debouncer and
// rising-edge detector. One accepted press gives exactly one btn_pulse.
module boton_pulso
    import contador_updown_mod_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic btn_level,
    output logic btn_pulse
);

    // The stable counter must be able to hold DEBOUNCE_CYCLES itself.
    localparam int CNT_W_RAW = clog2(DEBOUNCE_CYCLES + 1);
    localparam int CNT_W     = (CNT_W_RAW < 1) ? 1 : CNT_W_RAW;
    localparam logic [CNT_W-1:0] CNT_TARGET = CNT_W'(DEBOUNCE_CYCLES);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_level;
    logic             r_level_q;
    logic [CNT_W-1:0] r_stable_cnt;

    // Bring the asynchronous button into the clk domain.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= btn_raw;
            r_sync2 <= r_sync1;
        end
    end

    // Accept a new level only after DEBOUNCE_CYCLES differing samples in a row.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_level      <= 1'b0;
            r_stable_cnt <= '0;
        end else if (r_sync2 == r_level) begin
            r_stable_cnt <= '0;
        end else if (r_stable_cnt == CNT_TARGET) begin
            r_level      <= r_sync2;
            r_stable_cnt <= '0;
        end else begin
            r_stable_cnt <= r_stable_cnt + 1'b1;
        end
    end

    // Delayed copy of the debounced level for rising-edge detection.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_level_q <= 1'b0;
        end else begin
            r_level_q <= r_level;
        end
    end

    assign btn_level = r_level;
    assign btn_pulse = r_level & ~r_level_q;

endmodule

// File: rtl/contador_updown_mod.sv
// WIDTH-bit modulo-MODULO up/down counter driven by raw up/down buttons,
// with synchronous saturating load and one-cycle wrap flags.
module contador_updown_mod
    import contador_updown_mod_pkg::*;
#(
    parameter int WIDTH           = DEF_WIDTH,
    parameter int MODULO          = DEF_MODULO,
    parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
    parameter int INIT            = DEF_INIT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             up,
    input  logic             down,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] count,
    output logic             wrap_up,
    output logic             wrap_down
);

    // Top value kept one bit wider so MODULO == 2**WIDTH still compares correctly.
    localparam logic [WIDTH:0]   LP_MAX_EXT = (WIDTH + 1)'(MODULO - 1);
    localparam logic [WIDTH-1:0] LP_MAX     = LP_MAX_EXT[WIDTH-1:0];
    localparam logic [WIDTH-1:0] LP_INIT    = WIDTH'(INIT);

    logic [1:0]       w_btn_raw;
    logic [1:0]       w_btn_level;
    logic [1:0]       w_btn_pulse;
    logic             w_up_step;
    logic             w_down_step;
    logic             w_unused_levels;
    step_sel_e        w_sel;
    logic [WIDTH-1:0] w_count_next;
    logic             w_wrap_up_next;
    logic             w_wrap_down_next;
    logic [WIDTH-1:0] r_count;
    logic             r_wrap_up;
    logic             r_wrap_down;

    // Index 0 is the up button, index 1 the down button.
    assign w_btn_raw = {down, up};

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_btn
            boton_pulso #(
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_boton (
                .clk      (clk),
                .rst      (rst),
                .btn_raw  (w_btn_raw[gi]),
                .btn_level(w_btn_level[gi]),
                .btn_pulse(w_btn_pulse[gi])
            );
        end
    endgenerate

    assign w_up_step       = w_btn_pulse[0];
    assign w_down_step     = w_btn_pulse[1];
    // Debounced levels are not needed by the counter itself.
    assign w_unused_levels = &w_btn_level;

    // Priority: load, then simultaneous steps cancel, then up, then down.
    always_comb begin
        w_sel = SEL_HOLD;
        if (load) begin
            w_sel = SEL_LOAD;
        end else if (w_up_step && w_down_step) begin
            w_sel = SEL_CANCEL;
        end else if (w_up_step) begin
            w_sel = SEL_UP;
        end else if (w_down_step) begin
            w_sel = SEL_DOWN;
        end
    end

    // Modulo next-count and wrap flags for the selected action.
    always_comb begin
        w_count_next     = r_count;
        w_wrap_up_next   = 1'b0;
        w_wrap_down_next = 1'b0;
        case (w_sel)
            SEL_LOAD: begin
                w_count_next = ({1'b0, load_val} <= LP_MAX_EXT) ? load_val : LP_MAX;
            end
            SEL_UP: begin
                if ({1'b0, r_count} == LP_MAX_EXT) begin
                    w_count_next   = '0;
                    w_wrap_up_next = 1'b1;
                end else begin
                    w_count_next = r_count + 1'b1;
                end
            end
            SEL_DOWN: begin
                if (r_count == '0) begin
                    w_count_next     = LP_MAX;
                    w_wrap_down_next = 1'b1;
                end else begin
                    w_count_next = r_count - 1'b1;
                end
            end
            default: begin
            end
        endcase
    end

    // Count and wrap flags registered together so a flag lines up with its wrapped value.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_count     <= LP_INIT;
            r_wrap_up   <= 1'b0;
            r_wrap_down <= 1'b0;
        end else begin
            r_count     <= w_count_next;
            r_wrap_up   <= w_wrap_up_next;
            r_wrap_down <= w_wrap_down_next;
        end
    end

    assign count     = r_count;
    assign wrap_up   = r_wrap_up;
    assign wrap_down = r_wrap_down;

endmodule

// File: tb/tb_contador_updown_mod.sv
// Self-checking bench for contador_updown_mod: default instance plus a
// WIDTH=3 / MODULO=8 instance for the power-of-two boundary.
module tb_contador_updown_mod;

    typedef struct {
        logic [31:0] up_pat;
        logic [31:0] dn_pat;
        int          len;
        bit          ld;
        logic [3:0]  ld_val;
        logic [3:0]  exp_count;
        int          exp_wu;
        int          exp_wd;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       up = 1'b0, down = 1'b0, load = 1'b0;
    logic [3:0] load_val = 4'd0;
    logic [3:0] count;
    logic       wrap_up, wrap_down;

    logic       up2 = 1'b0, down2 = 1'b0, load2 = 1'b0;
    logic [2:0] load_val2 = 3'd0;
    logic [2:0] count2;
    logic       wrap_up2, wrap_down2;

    int n_tests = 0;
    int n_fail  = 0;
    int n_wu, n_wd, n_bad, n2_wu, n2_wd, n2_bad;

    vec_t vecs[$];

    always #5 clk = ~clk;

    contador_updown_mod u_dut (
        .clk      (clk),
        .rst      (rst),
        .up       (up),
        .down     (down),
        .load     (load),
        .load_val (load_val),
        .count    (count),
        .wrap_up  (wrap_up),
        .wrap_down(wrap_down)
    );

    contador_updown_mod #(
        .WIDTH (3),
        .MODULO(8)
    ) u_dut2 (
        .clk      (clk),
        .rst      (rst),
        .up       (up2),
        .down     (down2),
        .load     (load2),
        .load_val (load_val2),
        .count    (count2),
        .wrap_up  (wrap_up2),
        .wrap_down(wrap_down2)
    );

    function automatic vec_t mk(input logic [31:0] up_pat, input logic [31:0] dn_pat,
                                input int len, input bit ld, input logic [3:0] ld_val,
                                input logic [3:0] exp_count, input int exp_wu, input int exp_wd);
        vec_t r;
        r.up_pat    = up_pat;
        r.dn_pat    = dn_pat;
        r.len       = len;
        r.ld        = ld;
        r.ld_val    = ld_val;
        r.exp_count = exp_count;
        r.exp_wu    = exp_wu;
        r.exp_wd    = exp_wd;
        return r;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end else begin
            $display("ok   %s: got %0d", name, act);
        end
    endtask

    task automatic clear_mon();
        n_wu = 0; n_wd = 0; n_bad = 0;
        n2_wu = 0; n2_wd = 0; n2_bad = 0;
    endtask

    // One clock; sample both DUTs 1 time unit after the rising edge.
    task automatic cycle();
        @(posedge clk);
        #1;
        if (wrap_up) n_wu++;
        if (wrap_down) n_wd++;
        if ((wrap_up && count != 4'd0) || (wrap_down && count != 4'd9) || (wrap_up && wrap_down)) n_bad++;
        if (wrap_up2) n2_wu++;
        if (wrap_down2) n2_wd++;
        if ((wrap_up2 && count2 != 3'd0) || (wrap_down2 && count2 != 3'd7) || (wrap_up2 && wrap_down2)) n2_bad++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    initial begin
        // Table: glitches, bouncy press, load, ten ups with wrap, down wrap, cancel, saturating load.
        vecs.push_back(mk(32'h1,    32'h0, 1,  1'b0, 4'd0,  4'd1, 0, 0));
        vecs.push_back(mk(32'h3,    32'h0, 2,  1'b0, 4'd0,  4'd1, 0, 0));
        vecs.push_back(mk(32'h7,    32'h0, 3,  1'b0, 4'd0,  4'd1, 0, 0));
        vecs.push_back(mk(32'h233F, 32'h0, 14, 1'b0, 4'd0,  4'd2, 0, 0));
        vecs.push_back(mk(32'h0,    32'h0, 0,  1'b1, 4'd0,  4'd0, 0, 0));
        for (int k = 1; k <= 10; k++) begin
            vecs.push_back(mk(32'h3F, 32'h0, 6, 1'b0, 4'd0, 4'(k % 10), (k == 10) ? 1 : 0, 0));
        end
        vecs.push_back(mk(32'h0,    32'h3F, 6, 1'b0, 4'd0,  4'd9, 0, 1));
        vecs.push_back(mk(32'h3F,   32'h3F, 6, 1'b0, 4'd0,  4'd9, 0, 0));
        vecs.push_back(mk(32'h0,    32'h0, 0,  1'b1, 4'd3,  4'd3, 0, 0));
        vecs.push_back(mk(32'h0,    32'h0, 0,  1'b1, 4'd12, 4'd9, 0, 0));
        vecs.push_back(mk(32'h0,    32'h3F, 6, 1'b0, 4'd0,  4'd8, 0, 0));

        // Reset state.
        #1 rst = 1'b0;
        #1;
        check("reset count", count, 0);
        check("reset wrap_up", wrap_up, 0);
        check("reset wrap_down", wrap_down, 0);
        check("reset count2", count2, 0);
        @(posedge clk);
        #1 rst = 1'b1;
        idle(3);

        // Clean press: count changes exactly 7 edges after the first sampling edge.
        clear_mon();
        up = 1'b1;
        idle(7);
        check("latency count before step", count, 0);
        cycle();
        check("latency count at step", count, 1);
        idle(12);
        up = 1'b0;
        idle(25);
        check("held press count", count, 1);
        check("held press wrap_up", n_wu, 0);

        // Table-driven vectors.
        foreach (vecs[v]) begin
            clear_mon();
            for (int i = 0; i < ((vecs[v].len > 0) ? vecs[v].len : 1); i++) begin
                up       = vecs[v].up_pat[i];
                down     = vecs[v].dn_pat[i];
                load     = vecs[v].ld && (i == 0);
                load_val = vecs[v].ld_val;
                cycle();
            end
            up = 1'b0; down = 1'b0; load = 1'b0;
            idle(25);
            check($sformatf("vec%0d count", v), count, vecs[v].exp_count);
            check($sformatf("vec%0d wrap_up pulses", v), n_wu, vecs[v].exp_wu);
            check($sformatf("vec%0d wrap_down pulses", v), n_wd, vecs[v].exp_wd);
            check($sformatf("vec%0d flag/count coherence", v), n_bad, 0);
        end

        // Load (saturating) in the same cycle as an up step: step dropped.
        load = 1'b1; load_val = 4'd4;
        cycle();
        load = 1'b0;
        idle(3);
        check("pre load-vs-step count", count, 4);
        clear_mon();
        up = 1'b1;
        idle(7);
        load = 1'b1; load_val = 4'd12;
        cycle();
        load = 1'b0;
        check("load-vs-step count", count, 9);
        idle(15);
        up = 1'b0;
        idle(25);
        check("load-vs-step count later", count, 9);
        check("load-vs-step flags", n_wu + n_wd, 0);

        // Async reset mid-count with up held, then exactly one step after release.
        load = 1'b1; load_val = 4'd4;
        cycle();
        load = 1'b0;
        idle(2);
        clear_mon();
        up = 1'b1;
        idle(10);
        check("pre-reset count", count, 5);
        #2 rst = 1'b0;
        #1;
        check("async reset count", count, 0);
        check("async reset wrap_up", wrap_up, 0);
        @(posedge clk);
        #1 rst = 1'b1;
        idle(30);
        check("held-through-reset count", count, 1);
        up = 1'b0;
        idle(25);
        check("held-through-reset final count", count, 1);
        check("held-through-reset wrap_up", n_wu, 0);

        // WIDTH=3, MODULO=8 instance.
        clear_mon();
        load2 = 1'b1; load_val2 = 3'd7;
        cycle();
        load2 = 1'b0;
        check("w3 load 7 count", count2, 7);
        clear_mon();
        up2 = 1'b1;
        idle(6);
        up2 = 1'b0;
        idle(25);
        check("w3 wrap up count", count2, 0);
        check("w3 wrap_up pulses", n2_wu, 1);
        check("w3 wrap_down pulses", n2_wd, 0);
        check("w3 up coherence", n2_bad, 0);
        clear_mon();
        down2 = 1'b1;
        idle(6);
        down2 = 1'b0;
        idle(25);
        check("w3 wrap down count", count2, 7);
        check("w3 wrap_down pulses", n2_wd, 1);
        check("w3 down coherence", n2_bad, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
